tb_doutb_seq: RTL and testbench

TB_DOUTB_SEQ -- requirements
Module: tb_doutb_seq

---
 rtl/tb_doutb_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_tb_doutb_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tb_doutb_seq.sv
// ---------------------------------------------------------------------------
// tb_doutb_seq
//
// Read sequencer for the TB block RAM (port B). One accepted start runs one
// operation: a linear burst of `len` words, a fixed 8-beat transpose or
// inverse pattern, or an empty operation. The RAM returns data one cycle
// after the address, so the map select, beat index and landmark select are
// registered one cycle behind the address. This way they line up with
// TB_doutb.
//
// Parameters
//   TB_AW       TB port-B address width
//   SEQ_CNT_DW  width of seq_cnt_dout_sel
//   LEN_DW      width of the burst-length input
//
// Ports
//   clk              system clock, rising edge
//   sys_rst_n        asynchronous active-low reset
//   start            one-cycle request pulse, accepted only in IDLE
//   mode             requested map select code (sampled on accepted start)
//   l_k_0_in         landmark-half select (sampled on accepted start)
//   base_addr        first TB word address (sampled on accepted start)
//   len              word count for linear modes (sampled on accepted start)
//   TB_enb           TB port-B read enable
//   TB_addrb         TB port-B read address (holds when TB_enb is low)
//   TB_doutb_sel     map select aligned with TB_doutb
//   seq_cnt_dout_sel beat index aligned with TB_doutb
//   l_k_0            latched landmark-half select
//   busy             high in ISSUE and DRAIN
//   done             one-cycle completion pulse
// ---------------------------------------------------------------------------
module tb_doutb_seq #(
  parameter int TB_AW      = 10,
  parameter int SEQ_CNT_DW = 5,
  parameter int LEN_DW     = 8
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic                  l_k_0_in,
  input  logic [TB_AW-1:0]      base_addr,
  input  logic [LEN_DW-1:0]     len,
  output logic                  TB_enb,
  output logic [TB_AW-1:0]      TB_addrb,
  output logic [2:0]            TB_doutb_sel,
  output logic [SEQ_CNT_DW-1:0] seq_cnt_dout_sel,
  output logic                  l_k_0,
  output logic                  busy,
  output logic                  done
);

  // The beat counter must reach both len-1 and 7, the last fixed beat.
  localparam int KW = (LEN_DW > 3) ? LEN_DW : 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_reg;
  state_t                state_next;

  logic [2:0]            mode_reg;
  logic [TB_AW-1:0]      base_reg;
  logic [LEN_DW-1:0]     len_reg;
  logic                  lk0_reg;
  logic [KW-1:0]         k_reg;
  logic [TB_AW-1:0]      addr_last_reg;
  logic [2:0]            sel_reg;
  logic [SEQ_CNT_DW-1:0] seq_reg;

  // -------------------------------------------------------------------------
  // Mode classification
  // -------------------------------------------------------------------------
  function automatic logic is_linear(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b011) || (m == 3'b101);
  endfunction

  function automatic logic is_fixed(input logic [2:0] m);
    return (m == 3'b110) || (m == 3'b111);
  endfunction

  logic start_ok;     // start seen while IDLE
  logic start_beats;  // accepted operation has at least one beat
  logic cur_fixed;
  logic last_beat;
  logic [KW-1:0] len_m1;

  assign start_ok    = (state_reg == ST_IDLE) && start;
  assign start_beats = is_fixed(mode) || (is_linear(mode) && (len != '0));
  assign cur_fixed   = is_fixed(mode_reg);
  // Only evaluated in ISSUE. A linear op enters ISSUE only with len >= 1,
  // so len_m1 never underflows when it matters.
  assign len_m1      = KW'(len_reg) - KW'(1);
  assign last_beat   = cur_fixed ? (k_reg == KW'(7)) : (k_reg == len_m1);

  // -------------------------------------------------------------------------
  // Per-beat read decode
  // -------------------------------------------------------------------------
  // Fixed patterns. Beat 0 never reads. Beats 1..3 read base..base+2 in both
  // modes. Transpose then repeats base+2, base, base+1, base+2. Inverse
  // stays idle for beats 4..7.
  logic       fix_enb;
  logic [1:0] fix_off;

  always_comb begin
    fix_enb = 1'b0;
    fix_off = 2'd0;
    case (k_reg[2:0])
      3'd1: begin fix_enb = 1'b1;         fix_off = 2'd0; end
      3'd2: begin fix_enb = 1'b1;         fix_off = 2'd1; end
      3'd3: begin fix_enb = 1'b1;         fix_off = 2'd2; end
      3'd4: begin fix_enb = ~mode_reg[0]; fix_off = 2'd2; end
      3'd5: begin fix_enb = ~mode_reg[0]; fix_off = 2'd0; end
      3'd6: begin fix_enb = ~mode_reg[0]; fix_off = 2'd1; end
      3'd7: begin fix_enb = ~mode_reg[0]; fix_off = 2'd2; end
      default: begin fix_enb = 1'b0;      fix_off = 2'd0; end
    endcase
  end

  logic             beat_enb;
  logic [TB_AW-1:0] beat_off;
  logic [TB_AW-1:0] addr_calc;

  assign beat_enb  = cur_fixed ? fix_enb : 1'b1;
  assign beat_off  = cur_fixed ? TB_AW'(fix_off) : TB_AW'(k_reg);
  // The address width truncates the sum, so it wraps modulo 2^TB_AW.
  assign addr_calc = base_reg + beat_off;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          // Empty operations still pass through DRAIN and DONE. This keeps
          // done at a fixed distance of 2 cycles from start.
          state_next = start_beats ? ST_ISSUE : ST_DRAIN;
        end
      end
      ST_ISSUE: begin
        if (last_beat) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operation parameters, beat counter and aligned side-band registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_reg      <= 3'b000;
      base_reg      <= '0;
      len_reg       <= '0;
      lk0_reg       <= 1'b0;
      k_reg         <= '0;
      addr_last_reg <= '0;
      sel_reg       <= 3'b000;
      seq_reg       <= '0;
    end else begin
      if (start_ok) begin
        mode_reg <= mode;
        base_reg <= base_addr;
        len_reg  <= len;
        lk0_reg  <= l_k_0_in;
        k_reg    <= '0;
      end else if ((state_reg == ST_ISSUE) && !last_beat) begin
        k_reg <= k_reg + KW'(1);
      end

      // Remember the last issued address so the port holds it while idle.
      if (TB_enb) begin
        addr_last_reg <= addr_calc;
      end

      // Side-band follows the issued beat by one cycle, matching RAM latency.
      // Fixed modes report every beat, including beats that do not read.
      if (state_reg == ST_ISSUE) begin
        sel_reg <= mode_reg;
        seq_reg <= SEQ_CNT_DW'(k_reg);
      end else begin
        sel_reg <= 3'b000;
        seq_reg <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (derived only from reset-cleared registers, so an
  // asynchronous reset zeroes them immediately)
  // -------------------------------------------------------------------------
  always_comb begin
    TB_enb           = (state_reg == ST_ISSUE) && beat_enb;
    TB_addrb         = TB_enb ? addr_calc : addr_last_reg;
    TB_doutb_sel     = sel_reg;
    seq_cnt_dout_sel = seq_reg;
    l_k_0            = lk0_reg;
    busy             = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
    done             = (state_reg == ST_DONE);
  end

endmodule

// File: tb/tb_tb_doutb_seq.sv
// ---------------------------------------------------------------------------
// tb_tb_doutb_seq
//
// Bench for tb_doutb_seq. Each operation builds its expected cycle-by-cycle
// output (from start+1 through the first IDLE cycle after done) into a
// scoreboard queue. The entries are then popped and compared one cycle at
// a time, 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_tb_doutb_seq;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = 3'b000;
  logic       l_k_0_in = 1'b0;
  logic [9:0] base_addr = '0;
  logic [7:0] len = '0;
  logic       TB_enb;
  logic [9:0] TB_addrb;
  logic [2:0] TB_doutb_sel;
  logic [4:0] seq_cnt_dout_sel;
  logic       l_k_0;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  tb_doutb_seq #(
    .TB_AW(10),
    .SEQ_CNT_DW(5),
    .LEN_DW(8)
  ) dut (
    .clk(clk),
    .sys_rst_n(sys_rst_n),
    .start(start),
    .mode(mode),
    .l_k_0_in(l_k_0_in),
    .base_addr(base_addr),
    .len(len),
    .TB_enb(TB_enb),
    .TB_addrb(TB_addrb),
    .TB_doutb_sel(TB_doutb_sel),
    .seq_cnt_dout_sel(seq_cnt_dout_sel),
    .l_k_0(l_k_0),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       enb;
    logic [9:0] addr;
    logic [2:0] sel;
    logic [4:0] seq;
    logic       busy;
    logic       done;
    logic       lk;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] model_addr = '0;  // last address the port should be holding

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_enb"},  32'(TB_enb), 32'd0);
    check_eq({pfx, "_addr"}, 32'(TB_addrb), 32'd0);
    check_eq({pfx, "_sel"},  32'(TB_doutb_sel), 32'd0);
    check_eq({pfx, "_seq"},  32'(seq_cnt_dout_sel), 32'd0);
    check_eq({pfx, "_lk"},   32'(l_k_0), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_done"}, 32'(done), 32'd0);
  endtask

  // inj_c: cycle in which a bogus start is pulsed (0 = none).
  // rst_c: cycle in which reset is asserted (0 = none).
  task automatic run_op(input logic [2:0] m, input logic [9:0] b, input logic [7:0] l,
                        input logic lk, input int inj_c, input int rst_c);
    int offs[$];
    int nb;
    int c;
    int fail0;
    exp_t e;
    fail0 = failures;
    if (m == 3'b001 || m == 3'b010 || m == 3'b011 || m == 3'b101) begin
      for (int k = 0; k < int'(l); k++) offs.push_back(k);
    end else if (m == 3'b110) begin
      offs = '{-1, 0, 1, 2, 2, 0, 1, 2};
    end else if (m == 3'b111) begin
      offs = '{-1, 0, 1, 2, -1, -1, -1, -1};
    end
    nb = offs.size();
    for (int cc = 1; cc <= nb + 3; cc++) begin
      e.enb = (cc <= nb) && (offs[cc-1] >= 0);
      if (e.enb) model_addr = b + 10'(offs[cc-1]);
      e.addr = model_addr;
      if (cc >= 2 && cc <= nb + 1) begin
        e.sel = m;
        e.seq = 5'(cc - 2);
      end else begin
        e.sel = 3'b000;
        e.seq = 5'd0;
      end
      e.busy = (cc <= nb + 1);
      e.done = (cc == nb + 2);
      e.lk   = lk;
      exp_q.push_back(e);
    end

    mode = m; base_addr = b; len = l; l_k_0_in = lk; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs; the DUT must have sampled them on start.
    mode = 3'($urandom); base_addr = 10'($urandom); len = 8'($urandom); l_k_0_in = ~lk;
    c = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("c%0d_enb", c),  32'(TB_enb), 32'(e.enb));
      check_eq($sformatf("c%0d_addr", c), 32'(TB_addrb), 32'(e.addr));
      check_eq($sformatf("c%0d_sel", c),  32'(TB_doutb_sel), 32'(e.sel));
      check_eq($sformatf("c%0d_seq", c),  32'(seq_cnt_dout_sel), 32'(e.seq));
      check_eq($sformatf("c%0d_busy", c), 32'(busy), 32'(e.busy));
      check_eq($sformatf("c%0d_done", c), 32'(done), 32'(e.done));
      check_eq($sformatf("c%0d_lk", c),   32'(l_k_0), 32'(e.lk));
      if (c == inj_c) begin
        start = 1'b1; mode = 3'b111; base_addr = 10'h155; len = 8'd2;
      end else begin
        start = 1'b0;
      end
      if (c == rst_c) begin
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        exp_q.delete();
        model_addr = '0;
        break;
      end
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    $display("op mode=%b base=0x%03h len=%0d lk=%0d inj=%0d rst=%0d errors=%0d",
             m, b, l, lk, inj_c, rst_c, failures - fail0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    sys_rst_n = 1'b1;

    run_op(3'b001, 10'h010, 8'd4, 1'b0, 0, 0);    // basic linear burst
    run_op(3'b010, 10'h3FE, 8'd3, 1'b1, 0, 0);    // address wrap
    run_op(3'b110, 10'h020, 8'd5, 1'b1, 0, 0);    // transpose, len ignored
    run_op(3'b111, 10'h100, 8'd200, 1'b0, 0, 0);  // inverse, len ignored
    run_op(3'b011, 10'h0AA, 8'd0, 1'b1, 0, 0);    // linear len = 0
    run_op(3'b000, 10'h0BB, 8'd5, 1'b0, 0, 0);    // no-op mode
    run_op(3'b100, 10'h0CC, 8'd9, 1'b1, 0, 0);    // no-op mode
    run_op(3'b001, 10'h050, 8'd6, 1'b0, 3, 0);    // start while busy ignored
    run_op(3'b101, 10'h3F0, 8'd40, 1'b1, 0, 0);   // seq index wraps past 31
    run_op(3'b001, 10'h200, 8'd6, 1'b1, 0, 3);    // reset at beat 2

    // Reset held across an edge: nothing may come out, including done.
    @(posedge clk); #1;
    check_all_zero("rst_hold");
    sys_rst_n = 1'b1;
    // First start after release goes in on the very next edge.
    run_op(3'b001, 10'h123, 8'd2, 1'b0, 0, 0);
    run_op(3'b110, 10'h3FF, 8'd0, 1'b0, 0, 0);    // transpose wrapping

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net: the stimulus is finite, but never let a run hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
